// File: rtl/reduction_lut_loader.sv
// Runtime loader for the modular squarer's reduction LUT bank.
// Assembles CHUNK_LEN-bit stream beats into LUT_WIDTH-bit rows and writes them
// in order: RAM 0 rows 0..NUM_LUT_ENTRIES-1, then RAM 1, and so on.
// Within each RAM the lower half of the rows is the low half and the upper
// half is the high half. The host sends them in that order, so the loader
// needs no extra logic for the split.
// load_done stays low until the last row of the last RAM has been written.
module reduction_lut_loader #(
   parameter int NUM_ROMS        = 33,
   parameter int NUM_LUT_ENTRIES = 512,
   parameter int LUT_WIDTH       = 1024,
   parameter int CHUNK_LEN       = 32,
   localparam int SEL_W = (NUM_ROMS > 1) ? $clog2(NUM_ROMS) : 1,
   localparam int ROW_W = (NUM_LUT_ENTRIES > 1) ? $clog2(NUM_LUT_ENTRIES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_start,
   input  logic                 load_abort,
   input  logic                 cfg_valid,
   input  logic [CHUNK_LEN-1:0] cfg_data,
   output logic                 cfg_ready,
   output logic                 lut_we,
   output logic [SEL_W-1:0]     lut_sel,
   output logic [ROW_W-1:0]     lut_waddr,
   output logic [LUT_WIDTH-1:0] lut_wdata,
   output logic                 load_busy,
   output logic                 load_done
);

   localparam int CHUNKS  = LUT_WIDTH / CHUNK_LEN;
   localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
   localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NUM_LUT_ENTRIES - 1);
   localparam logic [SEL_W-1:0]   LAST_ROM   = SEL_W'(NUM_ROMS - 1);

   // A row must be a whole number of beats, otherwise packing is undefined
   generate
      if (LUT_WIDTH % CHUNK_LEN != 0) begin : g_bad_chunking
         $error("reduction_lut_loader: LUT_WIDTH must be a multiple of CHUNK_LEN");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [CHUNK_W-1:0]   chunk_cnt;
   logic [ROW_W-1:0]     row_cnt;
   logic [SEL_W-1:0]     rom_cnt;
   logic [LUT_WIDTH-1:0] asm_reg;
   logic [LUT_WIDTH-1:0] asm_next;
   logic                 accept;
   logic                 last_beat;
   logic                 final_entry;

   // The stream is only consumed while loading. Outside LOAD the host stalls.
   assign cfg_ready   = (state == LOAD);
   assign load_busy   = (state == LOAD);
   assign accept      = cfg_valid & cfg_ready;
   assign last_beat   = accept && (chunk_cnt == LAST_CHUNK);
   assign final_entry = (rom_cnt == LAST_ROM) && (row_cnt == LAST_ROW);

   // Next-state logic. Abort wins over start, and start is ignored while loading.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (load_start && !load_abort) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            if (load_abort) begin
               next_state = IDLE;
            end else if (last_beat && final_entry) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (load_abort) begin
               next_state = IDLE;
            end else if (load_start) begin
               next_state = LOAD;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Merge the incoming beat into its slot of the entry being assembled (LSB chunk first)
   always_comb begin
      asm_next = asm_reg;
      for (int k = 0; k < CHUNKS; k++) begin
         if (chunk_cnt == CHUNK_W'(k)) begin
            asm_next[k*CHUNK_LEN +: CHUNK_LEN] = cfg_data;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Chunk/row/rom counters and assembly buffer. Outside LOAD they are held at zero,
   // so any partial entry is discarded and every new load restarts at rom 0, row 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         chunk_cnt <= '0;
         row_cnt   <= '0;
         rom_cnt   <= '0;
         asm_reg   <= '0;
      end else if (state != LOAD) begin
         chunk_cnt <= '0;
         row_cnt   <= '0;
         rom_cnt   <= '0;
      end else if (accept) begin
         asm_reg <= asm_next;
         if (last_beat) begin
            chunk_cnt <= '0;
            if (row_cnt == LAST_ROW) begin
               row_cnt <= '0;
               rom_cnt <= (rom_cnt == LAST_ROM) ? '0 : rom_cnt + SEL_W'(1);
            end else begin
               row_cnt <= row_cnt + ROW_W'(1);
            end
         end else begin
            chunk_cnt <= chunk_cnt + CHUNK_W'(1);
         end
      end
   end

   // Write port. The completed entry is copied out here, which frees the assembly
   // buffer immediately and allows one beat per cycle. The address and data outputs
   // hold their last values when no write is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         lut_we    <= 1'b0;
         lut_sel   <= '0;
         lut_waddr <= '0;
         lut_wdata <= '0;
      end else begin
         lut_we <= last_beat;
         if (last_beat) begin
            lut_sel   <= rom_cnt;
            lut_waddr <= row_cnt;
            lut_wdata <= asm_next;
         end
      end
   end

   // load_done rises one cycle after the final write and clears when DONE is left
   always_ff @(posedge clk) begin
      if (reset) begin
         load_done <= 1'b0;
      end else begin
         load_done <= (state == DONE) && (next_state == DONE);
      end
   end

endmodule
